// File: rtl/ff_arb_pkg.sv
// Shared types and helpers for the burst-locking round-robin arbiter.
//   arb_state_e    : arbitration FSM states
//   beat_cnt_width : width of a counter that can hold 0..max_burst
//   slice_lo       : low bit of requester idx's word in a flattened bus
package ff_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic int unsigned beat_cnt_width(input int unsigned max_burst);
    return $clog2(max_burst + 1);
  endfunction

  function automatic int unsigned slice_lo(input int unsigned idx,
                                           input int unsigned size);
    return idx * size;
  endfunction

endpackage

// File: rtl/ff_burst_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   start : highest-priority index; the scan runs upward from here with wrap
//   grant : one-hot grant (zero when no request)
//   idx   : index of the granted request (0 when none)
//   any   : at least one request present
module rr_pick #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     start,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     idx,
  output logic               any
);

  always_comb begin
    int unsigned j;
    logic [IDW-1:0] jj;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    jj    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = 32'(start) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = IDW'(j);
      if (!any && req[jj]) begin
        any       = 1'b1;
        grant[jj] = 1'b1;
        idx       = jj;
      end
    end
  end

endmodule

// File: rtl/ff_burst_arbiter.sv
// Round-robin arbiter with burst locking in front of one registered
// valid/data output stage with downstream backpressure.
//   clk, reset_n : clock, asynchronous active-low reset
//   req_valid_i  : per-requester valid
//   req_data_i   : flattened requester data, requester i at [i*SIZE +: SIZE]
//   req_ready_o  : one-hot-or-zero acceptance per requester
//   ff_valid_o   : output register holds a word
//   ff_data_o    : registered word
//   ff_src_o     : requester index that produced ff_data_o
//   ff_ready_i   : downstream accepts the held word
module ff_burst_arbiter
  import ff_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ   = 4,
  parameter  int unsigned SIZE      = 32,
  parameter  int unsigned MAX_BURST = 4,
  localparam int unsigned IDW       = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [NUM_REQ*SIZE-1:0] req_data_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic                    ff_valid_o,
  output logic [SIZE-1:0]         ff_data_o,
  output logic [IDW-1:0]          ff_src_o,
  input  logic                    ff_ready_i
);

  localparam int unsigned BCW = beat_cnt_width(MAX_BURST);

  arb_state_e         state;
  logic [IDW-1:0]     owner;
  logic [IDW-1:0]     ptr;
  logic [BCW-1:0]     beat_cnt;

  logic               load_en;
  logic               xfer;
  logic               owner_valid;
  logic [IDW-1:0]     owner_next;
  logic [NUM_REQ-1:0] pick_req;
  logic [IDW-1:0]     pick_start;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;
  logic [SIZE-1:0]    words [NUM_REQ];
  logic [SIZE-1:0]    pick_word;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] i);
    return (i == IDW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  assign load_en     = !ff_valid_o | ff_ready_i;
  assign owner_valid = req_valid_i[owner];
  assign owner_next  = wrap_inc(owner);

  // One picker serves all cases: a held lock is expressed as a request
  // vector containing only the owner; an early release rescans from owner+1
  // in the same cycle so no bubble is inserted.
  always_comb begin
    pick_req   = req_valid_i;
    pick_start = ptr;
    if (state == LOCKED) begin
      if (owner_valid) begin
        pick_req        = '0;
        pick_req[owner] = 1'b1;
        pick_start      = owner;
      end else begin
        pick_start = owner_next;
      end
    end
  end

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req  (pick_req),
    .start(pick_start),
    .grant(grant),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      words[i] = req_data_i[slice_lo(i, SIZE) +: SIZE];
    end
  end

  assign pick_word = words[pick_idx];
  assign xfer      = load_en & pick_any;

  // Gated by reset_n so no requester sees ready while reset is asserted.
  assign req_ready_o = {NUM_REQ{load_en & reset_n}} & grant;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ff_valid_o <= 1'b0;
      ff_data_o  <= '0;
      ff_src_o   <= '0;
      state      <= IDLE;
      owner      <= '0;
      ptr        <= '0;
      beat_cnt   <= '0;
    end else if (load_en) begin
      ff_valid_o <= xfer;
      if (xfer) begin
        ff_data_o <= pick_word;
        ff_src_o  <= pick_idx;
      end
      unique case (state)
        IDLE: begin
          if (xfer) begin
            if (MAX_BURST > 1) begin
              state    <= LOCKED;
              owner    <= pick_idx;
              beat_cnt <= BCW'(1);
            end else begin
              ptr <= wrap_inc(pick_idx);
            end
          end
        end
        LOCKED: begin
          if (owner_valid) begin
            if (beat_cnt == BCW'(MAX_BURST - 1)) begin
              state    <= IDLE;
              ptr      <= owner_next;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end else begin
            ptr <= owner_next;
            if (xfer) begin
              owner    <= pick_idx;
              beat_cnt <= BCW'(1);
            end else begin
              state    <= IDLE;
              beat_cnt <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ff_burst_arbiter.sv
// Scoreboard bench for ff_burst_arbiter: two instances (MAX_BURST=4 and 1)
// share random stimulus; a reference model predicts grants and pushes the
// expected output words, a monitor pops them as words leave the stage.
module tb_ff_burst_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int NCYC = 600;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic           ff_ready;

  logic [N-1:0]   rdy_a, rdy_b;
  logic           v_a, v_b;
  logic [W-1:0]   d_a, d_b;
  logic [1:0]     s_a, s_b;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  ff_burst_arbiter #(.NUM_REQ(N), .SIZE(W), .MAX_BURST(4)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(rdy_a), .ff_valid_o(v_a), .ff_data_o(d_a), .ff_src_o(s_a),
    .ff_ready_i(ff_ready)
  );

  ff_burst_arbiter #(.NUM_REQ(N), .SIZE(W), .MAX_BURST(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(rdy_b), .ff_valid_o(v_b), .ff_data_o(d_b), .ff_src_o(s_b),
    .ff_ready_i(ff_ready)
  );

  // Reference model: pointer, current owner and beats the owner may still take.
  int  mb      [2] = '{4, 1};
  int  m_ptr   [2];
  int  m_owner [2];
  int  m_left  [2];
  bit  m_valid [2];
  logic [W+1:0] q0 [$];
  logic [W+1:0] q1 [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ptr[k] = 0; m_owner[k] = 0; m_left[k] = 0; m_valid[k] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_step(input int k, output logic [N-1:0] exp_rdy);
    int win;
    logic [W+1:0] w;
    exp_rdy = '0;
    win = -1;
    if (m_valid[k] && !ff_ready) return;
    if (m_left[k] > 0 && req_valid[m_owner[k]]) begin
      win = m_owner[k];
    end else begin
      if (m_left[k] > 0) begin
        m_ptr[k]  = (m_owner[k] + 1) % N;
        m_left[k] = 0;
      end
      for (int j = 0; j < N; j++)
        if (win < 0 && req_valid[(m_ptr[k] + j) % N]) win = (m_ptr[k] + j) % N;
      if (win >= 0) begin
        m_owner[k] = win;
        m_left[k]  = mb[k];
      end
    end
    if (win >= 0) begin
      m_left[k]--;
      if (m_left[k] == 0) m_ptr[k] = (win + 1) % N;
      exp_rdy[win] = 1'b1;
      w = {2'(win), req_data[win*W +: W]};
      if (k == 0) q0.push_back(w); else q1.push_back(w);
    end
    m_valid[k] = (win >= 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy_a"}, 64'(rdy_a), 64'd0);
    check({tag, "_rdy_b"}, 64'(rdy_b), 64'd0);
    check({tag, "_out_a"}, {29'd0, v_a, s_a, d_a}, 64'd0);
    check({tag, "_out_b"}, {29'd0, v_b, s_b, d_b}, 64'd0);
  endtask

  // Monitor: a word leaves on the coming edge when valid & ready.
  initial begin
    logic [W+1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && v_a && ff_ready) begin
        if (q0.size() == 0) check("sb0_underflow", {31'd0, v_a}, 64'd0);
        else begin e = q0.pop_front(); check("sb0_word", 64'({s_a, d_a}), 64'(e)); end
      end
      if (reset_n && v_b && ff_ready) begin
        if (q1.size() == 0) check("sb1_underflow", {31'd0, v_b}, 64'd0);
        else begin e = q1.pop_front(); check("sb1_word", 64'({s_b, d_b}), 64'(e)); end
      end
    end
  end

  initial begin
    logic [N-1:0] er;
    int mode;
    reset_n   = 1'b0;
    req_valid = '1;
    req_data  = '1;
    ff_ready  = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");

    for (int cyc = 0; cyc < NCYC + 12; cyc++) begin
      @(negedge clk);
      reset_n = 1'b1;
      mode = (cyc / 40) % 6;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom;
      case (mode)
        0: begin req_valid = '1; ff_ready = 1'b1; end
        1: begin
          req_valid = 4'b0010; ff_ready = 1'b1;
          req_data[W +: W] = 32'hA5A5_0000 + 32'(cyc);
        end
        2: begin req_valid = 4'($urandom); ff_ready = 1'($urandom); end
        3: begin req_valid = 4'($urandom); ff_ready = ($urandom_range(0, 4) == 0); end
        4: begin
          req_valid = {1'b1, 1'($urandom), 1'b0, ($urandom_range(0, 9) < 7)};
          ff_ready = 1'b1;
        end
        default: begin req_valid = 4'($urandom); ff_ready = ($urandom_range(0, 3) != 0); end
      endcase
      if (cyc >= NCYC) begin req_valid = '0; ff_ready = 1'b1; end
      #1;
      if (cyc == 300) begin
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        continue;
      end
      check("valid_a", 64'(v_a), 64'(m_valid[0]));
      check("valid_b", 64'(v_b), 64'(m_valid[1]));
      model_step(0, er);
      check("ready_a", 64'(rdy_a), 64'(er));
      model_step(1, er);
      check("ready_b", 64'(rdy_b), 64'(er));
    end

    @(negedge clk);
    #3;
    check("sb0_leftover", 64'(q0.size()), 64'd0);
    check("sb1_leftover", 64'(q1.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
